// File: rtl/fft_bfly_sched.sv
// -----------------------------------------------------------------------------
// fft_bfly_sched
// Butterfly scheduler for an in-place radix-2 DIT FFT. After a start request
// it steps through every stage s and every butterfly k of that stage. For
// each butterfly it offers one descriptor over a valid/ready handshake. The
// descriptor holds the two sample addresses (A, B) and the twiddle index.
// It also drives the stage-end and transform-end flags.
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          begin a full transform (honoured only while idle)
//   abort_i          synchronous abort back to idle, no done pulse
//   bfly_ready_i     sequencer accepts the current descriptor
//   bfly_valid_o     descriptor valid
//   addr_a_o         upper-leg sample address
//   addr_b_o         lower-leg sample address (addr_a_o + 2**stage)
//   tw_idx_o         twiddle index into the N/2-entry ROM
//   stage_o          current stage 0..LOG2N-1
//   last_in_stage_o  current butterfly is the last of its stage
//   last_bfly_o      current butterfly is the last of the transform
//   busy_o           high while descriptors are being issued
//   done_o           one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module fft_bfly_sched #(
  parameter int LOG2N = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     bfly_ready_i,
  output logic                     bfly_valid_o,
  output logic [LOG2N-1:0]         addr_a_o,
  output logic [LOG2N-1:0]         addr_b_o,
  output logic [LOG2N-2:0]         tw_idx_o,
  output logic [$clog2(LOG2N)-1:0] stage_o,
  output logic                     last_in_stage_o,
  output logic                     last_bfly_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int ADDR_W = LOG2N;
  localparam int TW_W   = LOG2N - 1;
  localparam int STG_W  = $clog2(LOG2N);
  localparam int K_W    = LOG2N - 1;

  localparam logic [K_W-1:0]   K_LAST = {K_W{1'b1}};
  localparam logic [K_W-1:0]   K_ZERO = {K_W{1'b0}};
  localparam logic [STG_W-1:0] S_LAST = STG_W'(LOG2N - 1);
  localparam logic [STG_W-1:0] S_ZERO = {STG_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e           state_r, state_n_s;
  logic [STG_W-1:0] s_r, s_n_s;
  logic [K_W-1:0]   k_r, k_n_s;

  logic              valid_s;
  logic              xfer_s;
  logic              last_in_stage_s;
  logic              last_bfly_s;
  logic [ADDR_W-1:0] k_ext_s;
  logic [ADDR_W-1:0] half_s;
  logic [ADDR_W-1:0] grp_s;
  logic [ADDR_W-1:0] pos_s;
  logic [ADDR_W-1:0] addr_a_s;
  logic [ADDR_W-1:0] addr_b_s;
  logic [TW_W-1:0]   tw_s;

  // State, stage and butterfly-index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      s_r     <= S_ZERO;
      k_r     <= K_ZERO;
    end else begin
      state_r <= state_n_s;
      s_r     <= s_n_s;
      k_r     <= k_n_s;
    end
  end

  // Descriptor and flags, decoded from the registered s, k and state only.
  always_comb begin
    valid_s         = 1'b0;
    k_ext_s         = {1'b0, k_r};
    half_s          = ADDR_W'(1) << s_r;
    grp_s           = k_ext_s >> s_r;
    // pos is the offset inside the group. grp is spread over groups of 2*half.
    pos_s           = k_ext_s & (half_s - ADDR_W'(1));
    addr_a_s        = ((grp_s << s_r) << 1'b1) | pos_s;
    addr_b_s        = addr_a_s | half_s;
    // pos < N/2, so it fits in the twiddle width before scaling.
    tw_s            = pos_s[TW_W-1:0] << (S_LAST - s_r);
    last_in_stage_s = 1'b0;
    last_bfly_s     = 1'b0;
    if (state_r == ST_ISSUE) begin
      valid_s         = 1'b1;
      last_in_stage_s = (k_r == K_LAST);
      last_bfly_s     = (k_r == K_LAST) && (s_r == S_LAST);
    end else begin
      valid_s         = 1'b0;
      last_in_stage_s = 1'b0;
      last_bfly_s     = 1'b0;
    end
    xfer_s = valid_s & bfly_ready_i;
  end

  // Next-state logic. Abort overrides start and any simultaneous transfer.
  always_comb begin
    state_n_s = state_r;
    s_n_s     = s_r;
    k_n_s     = k_r;
    if (abort_i) begin
      state_n_s = ST_IDLE;
      s_n_s     = S_ZERO;
      k_n_s     = K_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_n_s = ST_ISSUE;
            s_n_s     = S_ZERO;
            k_n_s     = K_ZERO;
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (xfer_s) begin
            if (last_bfly_s) begin
              state_n_s = ST_DONE;
              s_n_s     = S_ZERO;
              k_n_s     = K_ZERO;
            end else if (k_r == K_LAST) begin
              s_n_s = s_r + STG_W'(1);
              k_n_s = K_ZERO;
            end else begin
              k_n_s = k_r + K_W'(1);
            end
          end else begin
            state_n_s = ST_ISSUE;
          end
        end
        ST_DONE: begin
          state_n_s = ST_IDLE;
          s_n_s     = S_ZERO;
          k_n_s     = K_ZERO;
        end
        default: begin
          state_n_s = ST_IDLE;
          s_n_s     = S_ZERO;
          k_n_s     = K_ZERO;
        end
      endcase
    end
  end

  // Output drive: the descriptor is forced to zero whenever it is not valid.
  always_comb begin
    bfly_valid_o    = valid_s;
    busy_o          = valid_s;
    done_o          = (state_r == ST_DONE);
    last_in_stage_o = last_in_stage_s;
    last_bfly_o     = last_bfly_s;
    addr_a_o        = {ADDR_W{1'b0}};
    addr_b_o        = {ADDR_W{1'b0}};
    tw_idx_o        = {TW_W{1'b0}};
    stage_o         = S_ZERO;
    if (valid_s) begin
      addr_a_o = addr_a_s;
      addr_b_o = addr_b_s;
      tw_idx_o = tw_s;
      stage_o  = s_r;
    end else begin
      addr_a_o = {ADDR_W{1'b0}};
      addr_b_o = {ADDR_W{1'b0}};
      tw_idx_o = {TW_W{1'b0}};
      stage_o  = S_ZERO;
    end
  end

endmodule

// File: tb/tb_fft_bfly_sched.sv
module tb_fft_bfly_sched;

  localparam int L   = 3;
  localparam int N   = 1 << L;
  localparam int AW  = L;
  localparam int TWW = L - 1;
  localparam int SW  = $clog2(L);

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           start_i;
  logic           abort_i;
  logic           bfly_ready_i;
  logic           bfly_valid_o;
  logic [AW-1:0]  addr_a_o;
  logic [AW-1:0]  addr_b_o;
  logic [TWW-1:0] tw_idx_o;
  logic [SW-1:0]  stage_o;
  logic           last_in_stage_o;
  logic           last_bfly_o;
  logic           busy_o;
  logic           done_o;

  typedef struct {
    int a;
    int b;
    int tw;
    int stg;
    int lis;
    int lb;
  } desc_t;

  desc_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  fft_bfly_sched #(.LOG2N(L)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .bfly_ready_i    (bfly_ready_i),
    .bfly_valid_o    (bfly_valid_o),
    .addr_a_o        (addr_a_o),
    .addr_b_o        (addr_b_o),
    .tw_idx_o        (tw_idx_o),
    .stage_o         (stage_o),
    .last_in_stage_o (last_in_stage_o),
    .last_bfly_o     (last_bfly_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".valid"}, 32'(bfly_valid_o), 32'd0);
    chk({tag, ".busy"},  32'(busy_o),       32'd0);
    chk({tag, ".done"},  32'(done_o),       32'd0);
    chk({tag, ".a"},     32'(addr_a_o),     32'd0);
    chk({tag, ".b"},     32'(addr_b_o),     32'd0);
    chk({tag, ".tw"},    32'(tw_idx_o),     32'd0);
    chk({tag, ".stg"},   32'(stage_o),      32'd0);
    chk({tag, ".lis"},   32'(last_in_stage_o), 32'd0);
    chk({tag, ".lb"},    32'(last_bfly_o),  32'd0);
  endtask

  // Textbook DIT butterfly order: for each stage, walk the groups and the
  // positions inside each group. Twiddle exponent is pos * N/(2*span).
  task automatic build_ref();
    desc_t d;
    int    half;
    int    j;
    exp_q.delete();
    for (int s = 0; s < L; s++) begin
      half = 1 << s;
      j = 0;
      for (int g = 0; g < (N / 2) / half; g++) begin
        for (int p = 0; p < half; p++) begin
          d.a   = g * 2 * half + p;
          d.b   = d.a + half;
          d.tw  = p * (N / (2 * half));
          d.stg = s;
          d.lis = (j == N / 2 - 1) ? 1 : 0;
          d.lb  = (d.lis == 1 && s == L - 1) ? 1 : 0;
          j++;
          exp_q.push_back(d);
        end
      end
    end
  endtask

  // mode: 0 ready always, 1 random ready, 2 ready held low 5 cycles on s1,k1
  task automatic run_xfm(input int mode, input bit stray, input int abort_at, input int rst_at);
    int  idx;
    int  hold;
    bit  rdy;
    bit  ab;
    build_ref();
    idx  = 0;
    hold = 0;
    start_i = 1'b1; abort_i = 1'b0; bfly_ready_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
      if (idx == rst_at) begin
        start_i = 1'b0; bfly_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk_quiet("rst_mid");
        rst_ni = 1'b1;
        step();
        chk_quiet("rst_after1");
        step();
        chk_quiet("rst_after2");
        return;
      end
      chk("valid", 32'(bfly_valid_o), 32'd1);
      chk("busy",  32'(busy_o),       32'd1);
      chk("done_early", 32'(done_o),  32'd0);
      chk("addr_a", 32'(addr_a_o), 32'(exp_q[0].a));
      chk("addr_b", 32'(addr_b_o), 32'(exp_q[0].b));
      chk("tw_idx", 32'(tw_idx_o), 32'(exp_q[0].tw));
      chk("stage",  32'(stage_o),  32'(exp_q[0].stg));
      chk("last_in_stage", 32'(last_in_stage_o), 32'(exp_q[0].lis));
      chk("last_bfly",     32'(last_bfly_o),     32'(exp_q[0].lb));
      if (mode == 1) begin
        rdy = ($urandom_range(0, 1) == 1);
      end else if (mode == 2 && idx == 5 && hold < 5) begin
        rdy = 1'b0;
        hold++;
      end else begin
        rdy = 1'b1;
      end
      ab = (idx == abort_at);
      bfly_ready_i = rdy;
      abort_i = ab;
      start_i = stray ? ($urandom_range(0, 1) == 1) : 1'b0;
      step();
      if (ab) begin
        abort_i = 1'b0; start_i = 1'b0; bfly_ready_i = 1'b0;
        chk_quiet("abort1");
        step();
        chk_quiet("abort2");
        step();
        chk_quiet("abort3");
        return;
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        idx++;
      end
    end
    chk("timeout_left", 32'(exp_q.size()), 32'd0);
    bfly_ready_i = 1'b0;
    chk("done",        32'(done_o),       32'd1);
    chk("done.valid",  32'(bfly_valid_o), 32'd0);
    chk("done.busy",   32'(busy_o),       32'd0);
    // a start seen in DONE must be ignored
    start_i = stray;
    step();
    start_i = 1'b0;
    chk_quiet("post_done");
    step();
    chk_quiet("idle2");
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; bfly_ready_i = 1'b0;
    step();
    step();
    chk_quiet("reset");
    rst_ni = 1'b1;
    step();
    chk_quiet("after_reset");

    // start and abort together in IDLE: stays idle
    start_i = 1'b1; abort_i = 1'b1;
    step();
    start_i = 1'b0; abort_i = 1'b0;
    chk_quiet("start_abort");
    step();
    chk_quiet("start_abort2");

    run_xfm(0, 1'b0, -1, -1);
    run_xfm(2, 1'b0, -1, -1);
    run_xfm(0, 1'b0, 6, -1);
    run_xfm(0, 1'b0, -1, -1);
    for (int r = 0; r < 3; r++) begin
      run_xfm(1, 1'b1, -1, -1);
    end
    run_xfm(1, 1'b0, -1, 7);
    run_xfm(1, 1'b1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
